// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//
// APB initiator. Accepts one command at a time on a valid/ready stream,
// decodes the slave select from the address, runs one APB transfer
// (SETUP then ACCESS, with PREADY wait states and a bounded timeout) and
// returns the result on a valid/ready response stream.
//
// Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write/addr/wdata  command fields; cmd_strb only used with APB4_EN
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    read data (0 for writes/errors),
//                         error code 00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT
//   PSEL..PWDATA          APB request signals (PSEL one-hot over P_NUM)
//   PRDATA/PREADY/PSLVERR per-slave APB returns, slave k at [32k+:32] / [k]
//
// Optional build macro
//   APB4_EN  adds PPROT (tied 3'b000) and PSTRB (latched cmd_strb on writes,
//            0 on reads). Without it cmd_strb is ignored.
// ---------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int unsigned P_NUM      = 4,
  parameter int unsigned P_SLV_BITS = 10,
  parameter logic [31:0] P_BASE     = 32'h0000_0000,
  parameter int unsigned P_TIMEOUT  = 256
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [31:0]            cmd_addr,
  input  logic [31:0]            cmd_wdata,
  input  logic [3:0]             cmd_strb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_err,
  output logic [P_NUM-1:0]       PSEL,
  output logic [31:0]            PADDR,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  input  logic [32*P_NUM-1:0]    PRDATA,
  input  logic [P_NUM-1:0]       PREADY,
  input  logic [P_NUM-1:0]       PSLVERR
`ifdef APB4_EN
  ,
  output logic [2:0]             PPROT,
  output logic [3:0]             PSTRB
`endif
);

  localparam int unsigned IDX_W = (P_NUM > 1) ? $clog2(P_NUM) : 1;
  localparam int unsigned CNT_W = $clog2(P_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SLV = 2'b01;
  localparam logic [1:0] ERR_DEC = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  state_e             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        addr_q, addr_d;
  logic               write_q, write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef APB4_EN
  logic [3:0]         strb_q, strb_d;
`else
  logic               unused_strb;
  assign unused_strb = ^cmd_strb;
`endif

  // Address decode. The subtraction wraps for addresses below P_BASE, so the
  // lower bound is checked separately.
  logic [31:0] offset;
  logic [31:0] slot;
  logic        in_range;
  assign offset   = cmd_addr - P_BASE;
  assign slot     = offset >> P_SLV_BITS;
  assign in_range = (cmd_addr >= P_BASE) && (slot < P_NUM);

  // Return path of the selected slave only; the others are ignored.
  logic        sel_ready;
  logic        sel_err;
  logic [31:0] sel_rdata;
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < P_NUM; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready = PREADY[k];
        sel_err   = PSLVERR[k];
        sel_rdata = PRDATA[32*k +: 32];
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef APB4_EN
    strb_d  = strb_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (in_range) begin
            idx_d   = slot[IDX_W-1:0];
            addr_d  = cmd_addr;
            write_d = cmd_write;
            wdata_d = cmd_wdata;
`ifdef APB4_EN
            strb_d  = cmd_write ? cmd_strb : 4'b0000;
`endif
            state_d = S_SETUP;
          end else begin
            // Undecodable: answer at once, APB bus untouched.
            rdata_d = '0;
            err_d   = ERR_DEC;
            state_d = S_RESP;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_W'(1);
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // PREADY is tested before the timeout so a late ready still wins.
        if (sel_ready) begin
          rdata_d = (!write_q && !sel_err) ? sel_rdata : '0;
          err_d   = sel_err ? ERR_SLV : ERR_OK;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(P_TIMEOUT)) begin
          rdata_d = '0;
          err_d   = ERR_TMO;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered so that cmd_ready stays low through reset and rises only on
  // the first edge after PRESET is released.
  assign cmd_ready_d = (state_d == S_IDLE);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      idx_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
      cnt_q       <= '0;
`ifdef APB4_EN
      strb_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef APB4_EN
      strb_q      <= strb_d;
`endif
    end
  end

  // APB request: address/data registers keep their last values between
  // transfers; only PSEL and PENABLE fall back to 0.
  always_comb begin
    PSEL = '0;
    if (state_q == S_SETUP || state_q == S_ACCESS) begin
      for (int k = 0; k < P_NUM; k++) begin
        if (idx_q == IDX_W'(k)) PSEL[k] = 1'b1;
      end
    end
  end

  assign PENABLE   = (state_q == S_ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
`ifdef APB4_EN
  assign PPROT     = 3'b000;
  assign PSTRB     = strb_q;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
//
// Directed bench for apb_cmd_master (P_NUM=4, 1 KiB windows, P_TIMEOUT=8).
// Four behavioural slaves with a per-slave PREADY delay, a stuck-low option
// and a PSLVERR option. Unselected slaves drive PREADY=1, PSLVERR=1 and junk
// PRDATA so that any use of them by the DUT shows up. Slave memory is
// reloaded with the pattern A0kk_wwww (k = slave, w = word) on PRESET.
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;

  localparam int NUM = 4;
  localparam int TMO = 8;

  logic               PCLK = 1'b0;
  logic               PRESET;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [31:0]        cmd_addr;
  logic [31:0]        cmd_wdata;
  logic [3:0]         cmd_strb;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_rdata;
  logic [1:0]         rsp_err;
  logic [NUM-1:0]     PSEL;
  logic [31:0]        PADDR;
  logic               PENABLE;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [32*NUM-1:0]  PRDATA;
  logic [NUM-1:0]     PREADY;
  logic [NUM-1:0]     PSLVERR;
`ifdef APB4_EN
  logic [2:0]         PPROT;
  logic [3:0]         PSTRB;
`endif

  always #5 PCLK = ~PCLK;

  apb_cmd_master #(
    .P_NUM      (NUM),
    .P_SLV_BITS (10),
    .P_BASE     (32'h0000_0000),
    .P_TIMEOUT  (TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PADDR     (PADDR),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
`ifdef APB4_EN
    ,
    .PPROT     (PPROT),
    .PSTRB     (PSTRB)
`endif
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [NUM][256];
  int          delay [NUM];
  logic [NUM-1:0] stuck;
  logic        slverr_on;
  int          acc_cnt = 0;

  always @(posedge PCLK) begin
    if (PENABLE) acc_cnt <= acc_cnt + 1;
    else         acc_cnt <= 0;
    if (PRESET) begin
      for (int k = 0; k < NUM; k++)
        for (int w = 0; w < 256; w++)
          mem[k][w] <= 32'hA000_0000 | (k << 16) | w;
    end else begin
      for (int k = 0; k < NUM; k++)
        if (PSEL[k] && PENABLE && PREADY[k] && PWRITE && !slverr_on)
          mem[k][PADDR[9:2]] <= PWDATA;
    end
  end

  always_comb begin
    PREADY  = '0;
    PSLVERR = '0;
    PRDATA  = '0;
    for (int k = 0; k < NUM; k++) begin
      if (PSEL[k]) begin
        PREADY[k]          = PENABLE && !stuck[k] && (acc_cnt >= delay[k]);
        PSLVERR[k]         = slverr_on;
        PRDATA[32*k +: 32] = mem[k][PADDR[9:2]];
      end else begin
        PREADY[k]          = 1'b1;
        PSLVERR[k]         = 1'b1;
        PRDATA[32*k +: 32] = 32'hBAD0_0000 | k;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observations from the last run_cmd.
  logic [NUM-1:0] psel_or;
  int             psel_cycles;
  int             pen_cycles;
  logic           stable_ok;
  logic [31:0]    first_paddr;

  // Issue one command, track the APB bus until rsp_valid, optionally stall
  // rsp_ready, then consume the response. lat = edges from accept to the
  // first cycle rsp_valid is seen high.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall, output int lat,
                         output logic [31:0] rdata, output logic [1:0] err);
    int             n;
    logic           first;
    logic [NUM-1:0] s_psel;
    logic [31:0]    s_pwdata;
    logic           s_pwrite;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = 4'hF;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid   = 1'b0;
    lat         = 1;
    psel_or     = '0;
    psel_cycles = 0;
    pen_cycles  = 0;
    stable_ok   = 1'b1;
    first       = 1'b1;
    first_paddr = '0;
    s_psel      = '0;
    s_pwdata    = '0;
    s_pwrite    = 1'b0;
    while (!rsp_valid && lat < 50) begin
      if (PSEL != '0) begin
        psel_cycles++;
        psel_or |= PSEL;
        if (PENABLE) pen_cycles++;
        if (first) begin
          first       = 1'b0;
          first_paddr = PADDR;
          s_psel      = PSEL;
          s_pwdata    = PWDATA;
          s_pwrite    = PWRITE;
        end else if (PSEL != s_psel || PADDR != first_paddr ||
                     PWDATA != s_pwdata || PWRITE != s_pwrite) begin
          stable_ok = 1'b0;
        end
      end
      @(negedge PCLK);
      lat++;
    end
    check("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge PCLK);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rdata", rsp_rdata, rdata);
      check("stall_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [1:0]  er;
    int          n;

    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    slverr_on = 1'b0;
    stuck     = '0;
    for (int k = 0; k < NUM; k++) delay[k] = 0;

    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_psel",      {28'd0, PSEL}, 32'd0);
    check("rst_penable",   {31'd0, PENABLE}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_paddr",     PADDR, 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("cmd_ready_rise", {31'd0, cmd_ready}, 32'd1);

    // Zero-wait write to slave 1
    run_cmd(1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 0, lat, rd, er);
    check("wr_lat",       lat, 32'd3);
    check("wr_psel",      {28'd0, psel_or}, 32'h2);
    check("wr_psel_cyc",  psel_cycles, 32'd2);
    check("wr_pen_cyc",   pen_cycles, 32'd1);
    check("wr_paddr",     first_paddr, 32'h0000_0404);
    check("wr_stable",    {31'd0, stable_ok}, 32'd1);
    check("wr_err",       {30'd0, er}, 32'd0);
    check("wr_rdata",     rd, 32'd0);
    check("paddr_hold",   PADDR, 32'h0000_0404);
    check("psel_idle",    {28'd0, PSEL}, 32'd0);

    // Read it back
    run_cmd(1'b0, 32'h0000_0404, 32'h0, 0, lat, rd, er);
    check("rd_lat",   lat, 32'd3);
    check("rd_rdata", rd, 32'hDEAD_BEEF);
    check("rd_err",   {30'd0, er}, 32'd0);

    // Slave 3, PREADY after 5 wait states
    delay[3] = 5;
    run_cmd(1'b0, 32'h0000_0C08, 32'h0, 0, lat, rd, er);
    check("wait_lat",     lat, 32'd8);
    check("wait_pen_cyc", pen_cycles, 32'd6);
    check("wait_psel",    {28'd0, psel_or}, 32'h8);
    check("wait_stable",  {31'd0, stable_ok}, 32'd1);
    check("wait_rdata",   rd, 32'hA003_0002);
    check("wait_err",     {30'd0, er}, 32'd0);
    delay[3] = 0;

    // Decode error: idx 4 of 4
    run_cmd(1'b1, 32'h0000_1000, 32'h1234_5678, 0, lat, rd, er);
    check("dec_lat",   lat, 32'd1);
    check("dec_psel",  {28'd0, psel_or}, 32'd0);
    check("dec_err",   {30'd0, er}, 32'd2);
    check("dec_rdata", rd, 32'd0);

    // Slave error on a read
    slverr_on = 1'b1;
    run_cmd(1'b0, 32'h0000_0008, 32'h0, 0, lat, rd, er);
    check("slv_err",   {30'd0, er}, 32'd1);
    check("slv_rdata", rd, 32'd0);
    slverr_on = 1'b0;

    // Timeout on a stuck slave, then a normal transfer
    stuck[1] = 1'b1;
    run_cmd(1'b0, 32'h0000_0400, 32'h0, 0, lat, rd, er);
    check("tmo_err",     {30'd0, er}, 32'd3);
    check("tmo_pen_cyc", pen_cycles, TMO);
    check("tmo_lat",     lat, TMO + 2);
    check("tmo_rdata",   rd, 32'd0);
    stuck[1] = 1'b0;
    run_cmd(1'b0, 32'h0000_0010, 32'h0, 0, lat, rd, er);
    check("post_tmo_err",   {30'd0, er}, 32'd0);
    check("post_tmo_rdata", rd, 32'hA000_0004);

    // Reset pulsed during ACCESS
    delay[2] = 5;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0804;
    cmd_wdata = 32'h5555_AAAA;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    n = 0;
    while (!PENABLE && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check("mid_in_access", {31'd0, PENABLE}, 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("mid_psel",      {28'd0, PSEL}, 32'd0);
    check("mid_penable",   {31'd0, PENABLE}, 32'd0);
    check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_paddr",     PADDR, 32'd0);
    check("mid_pwdata",    PWDATA, 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("mid_idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_no_rsp",     {31'd0, rsp_valid}, 32'd0);
    delay[2] = 0;

    // Response held through a 3-cycle rsp_ready stall
    run_cmd(1'b0, 32'h0000_080C, 32'h0, 3, lat, rd, er);
    check("stall_lat",   lat, 32'd3);
    check("stall_rd",    rd, 32'hA002_0003);
    check("stall_err",   {30'd0, er}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
